// File: rtl/abba_gen.sv
// -----------------------------------------------------------------------------
// abba_gen
//
// Purpose:
//   Emits the four-symbol string a, b, b, a on a 2-bit symbol bus, repeated a
//   programmable number of times. It feeds the `x` input of the downstream
//   string recognizers. The outputs are decoded from the state register only.
//   A valid/ready handshake lets a stalled consumer hold the current symbol
//   without it being lost or duplicated.
//
// Optional feature:
//   ABBA_GEN_GAP_EN - when defined, a one-cycle GAP state (x=11, valid=0) is
//                     inserted between consecutive strings. There is no GAP
//                     after the last string.
//
// Ports:
//   clock  in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset
//   start  in   1      transmission request; sampled only in IDLE
//   count  in   N_REP  number of strings; captured together with start
//   ready  in   1      consumer accepts the current symbol
//   x      out  [1:2]  symbol: a=00, b=01, idle/filler=11
//   valid  out  1      x carries a string symbol
//   busy   out  1      block is not in IDLE
//   done   out  1      one-cycle pulse after the last symbol is accepted
// -----------------------------------------------------------------------------
module abba_gen #(
    parameter int N_REP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [N_REP-1:0] count,
    input  logic             ready,
    output logic [1:2]       x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A1   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_A2   = 3'd4,
        S_DONE = 3'd5
`ifdef ABBA_GEN_GAP_EN
        , S_GAP = 3'd6
`endif
    } state_t;

    localparam logic [1:2] SYM_A    = 2'b00;
    localparam logic [1:2] SYM_B    = 2'b01;
    localparam logic [1:2] SYM_IDLE = 2'b11;

    state_t           r_state;
    state_t           w_state_next;
    logic [N_REP-1:0] r_reps_left;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Remaining-repetition counter. The exit test (reps_left == 1) is made
    // before any decrement, so the counter never wraps below 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_reps_left <= '0;
        end else if (r_state == S_IDLE && start && count != '0) begin
            r_reps_left <= count;
        end else if (r_state == S_A2 && ready && r_reps_left != N_REP'(1)) begin
            r_reps_left <= r_reps_left - N_REP'(1);
        end
    end

    // Next-state logic. The symbol states always have valid=1, so ready
    // alone marks the acceptance of the current symbol.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (count != '0) ? S_A1 : S_DONE;
                end
            end
            S_A1: if (ready) w_state_next = S_B1;
            S_B1: if (ready) w_state_next = S_B2;
            S_B2: if (ready) w_state_next = S_A2;
            S_A2: begin
                if (ready) begin
                    if (r_reps_left == N_REP'(1)) begin
                        w_state_next = S_DONE;
                    end else begin
`ifdef ABBA_GEN_GAP_EN
                        w_state_next = S_GAP;
`else
                        w_state_next = S_A1;
`endif
                    end
                end
            end
`ifdef ABBA_GEN_GAP_EN
            // The gap is never stretched by a stalled consumer.
            S_GAP:  w_state_next = S_A1;
`endif
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode, which depends on state only.
    always_comb begin
        x     = SYM_IDLE;
        valid = 1'b0;
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
        case (r_state)
            S_A1, S_A2: begin
                x     = SYM_A;
                valid = 1'b1;
            end
            S_B1, S_B2: begin
                x     = SYM_B;
                valid = 1'b1;
            end
            default: begin
                x     = SYM_IDLE;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_abba_gen.sv
// -----------------------------------------------------------------------------
// tb_abba_gen
//
// Purpose:
//   Directed testbench for abba_gen. It drives start, count and ready and
//   checks x, valid, busy and done on every cycle against expected values
//   built in the bench. A small behavioural abba recognizer counts the
//   strings that are accepted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_abba_gen;

    localparam int N_REP = 4;
`ifdef ABBA_GEN_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    logic             clock;
    logic             reset;
    logic             start;
    logic [N_REP-1:0] count;
    logic             ready;
    logic [1:2]       x;
    logic             valid;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] sym_tab [4];

    // Behavioural recognizer state (non-overlapping a-b-b-a detection)
    logic [7:0] rec_hist;
    int         rec_nsym;
    int         det_cnt = 0;

    abba_gen #(.N_REP(N_REP)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .count (count),
        .ready (ready),
        .x     (x),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_hist <= 8'h00;
            rec_nsym <= 0;
        end else if (valid && ready) begin
            if ({rec_hist[5:0], x} == 8'b00_01_01_00 && rec_nsym >= 3) begin
                det_cnt  <= det_cnt + 1;
                rec_hist <= 8'h00;
                rec_nsym <= 0;
            end else begin
                rec_hist <= {rec_hist[5:0], x};
                rec_nsym <= (rec_nsym < 3) ? rec_nsym + 1 : 3;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transmission of k strings with ready=1. The consumer stalls
    // for stall_len cycles on the global symbol with index stall_idx
    // (pass -1 for no stall).
    task automatic run(input int k, input int stall_idx, input int stall_len);
        int cyc;
        int det_base;
        int exp_cyc;
        det_base = det_cnt;
        start = 1'b1;
        count = N_REP'(k);
        ready = 1'b1;
        step();
        start = 1'b0;
        count = N_REP'(0);
        cyc = 0;
        for (int s = 0; s < k; s++) begin
            for (int j = 0; j < 4; j++) begin
                if (s * 4 + j == stall_idx) begin
                    ready = 1'b0;
                    for (int m = 0; m < stall_len; m++) begin
                        chk("stall_x", int'(x), int'(sym_tab[j]));
                        chk("stall_valid", int'(valid), 1);
                        step();
                        cyc++;
                    end
                    ready = 1'b1;
                end
                chk("sym_x", int'(x), int'(sym_tab[j]));
                chk("sym_valid", int'(valid), 1);
                chk("sym_busy", int'(busy), 1);
                chk("sym_done", int'(done), 0);
                step();
                cyc++;
            end
            if (GAP_EN != 0 && s < k - 1) begin
                ready = 1'b0;  // the gap must not wait for ready
                chk("gap_x", int'(x), 3);
                chk("gap_valid", int'(valid), 0);
                step();
                cyc++;
                ready = 1'b1;
            end
        end
        exp_cyc = 4 * k + ((GAP_EN != 0) ? k - 1 : 0)
                  + ((stall_idx >= 0 && stall_idx < 4 * k) ? stall_len : 0);
        chk("total_cycles", cyc, exp_cyc);
        chk("end_done", int'(done), 1);
        chk("end_valid", int'(valid), 0);
        chk("end_busy", int'(busy), 1);
        chk("end_x", int'(x), 3);
        chk("detections", det_cnt - det_base, k);
        step();
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_x", int'(x), 3);
        $display("run count=%0d stall_idx=%0d stall_len=%0d cycles=%0d detections=%0d",
                 k, stall_idx, stall_len, cyc, det_cnt - det_base);
    endtask

    initial begin
        sym_tab[0] = 2'b00;
        sym_tab[1] = 2'b01;
        sym_tab[2] = 2'b01;
        sym_tab[3] = 2'b00;
        reset = 1'b0;
        start = 1'b0;
        count = '0;
        ready = 1'b1;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_x", int'(x), 3);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        step();
        #3 reset = 1'b0;
        $display("reset state checked");

        // Single string, then three strings, then a stall on B2
        run(1, -1, 0);
        run(3, -1, 0);
        run(2, 2, 3);

        // count=0: DONE on the next cycle; a start during DONE is ignored
        start = 1'b1;
        count = N_REP'(0);
        step();
        chk("zero_done", int'(done), 1);
        chk("zero_valid", int'(valid), 0);
        chk("zero_busy", int'(busy), 1);
        start = 1'b1;
        count = N_REP'(2);
        step();
        start = 1'b0;
        chk("zero_after_busy", int'(busy), 0);
        chk("zero_after_valid", int'(valid), 0);
        chk("zero_after_done", int'(done), 0);
        step();
        chk("zero_ignored_valid", int'(valid), 0);
        chk("zero_ignored_busy", int'(busy), 0);
        $display("count=0 with start during DONE checked");

        // Asynchronous reset during B1 of the second string
        start = 1'b1;
        count = N_REP'(3);
        step();
        start = 1'b0;
        for (int i = 0; i < 4 + GAP_EN; i++) step();
        step();
        chk("pre_rst_x", int'(x), 1);
        chk("pre_rst_valid", int'(valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_x", int'(x), 3);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        step();
        #3 reset = 1'b0;
        $display("asynchronous reset during B1 checked");
        run(2, -1, 0);

        // Maximum count
        run(15, -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
